data_mem_responder: RTL and testbench

- Responder side of the data-memory interface driven by the CPU main control decoder (mem_read / mem_write) and the ALU address path.
- Holds a word-organised data RAM and serves RV32I loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW) with configurable wait states.
- Stalls the pipeline until each access completes.
- Flags misaligned and illegal-width accesses instead of performing them.

---
 rtl/data_mem_responder_if.sv | 22 ++
 rtl/data_mem_responder.sv | 199 +++++++++++++++++++
 tb/tb_data_mem_responder.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Data-memory handshake between the CPU (master) and the memory responder (slave).
interface data_mem_if;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        done;
    logic        fault;

    modport master (
        output mem_read, mem_write, funct3, addr, wdata,
        input  rdata, stall, done, fault
    );

    modport slave (
        input  mem_read, mem_write, funct3, addr, wdata,
        output rdata, stall, done, fault
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: word-organised RAM serving RV32I loads/stores with
// a fixed number of wait states, a stall to the pipeline and fault flagging
// for misaligned or illegal-width accesses.
module data_mem_responder #(
    parameter int DEPTH   = 1024,
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic       clk,
    input  logic       rst,
    data_mem_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_t;

    localparam logic [3:0] LAT = 4'(LATENCY);

    logic [31:0]       ram [DEPTH];

    state_t            state_r;
    state_t            state_nxt_s;
    logic [3:0]        cnt_r;
    logic [3:0]        cnt_nxt_s;
    logic              enter_resp_s;

    logic [ADDR_W+1:0] addr_r;
    logic [31:0]       wdata_r;
    logic [2:0]        f3_r;
    logic              store_r;
    logic [31:0]       word_r;
    logic [31:0]       rdata_r;
    logic              done_r;
    logic              fault_r;

    logic              req_s;
    logic [ADDR_W+1:0] sel_addr_s;
    logic [2:0]        sel_f3_s;
    logic              sel_store_s;
    logic              sel_fault_s;
    logic [31:0]       sel_word_s;

    // Fault rule: misaligned half/word, reserved funct3, or unsigned-width store.
    function automatic logic access_fault(input logic [2:0] f3, input logic [1:0] lo,
                                          input logic st);
        logic f;
        case (f3)
            3'b000, 3'b100: f = 1'b0;
            3'b001, 3'b101: f = lo[0];
            3'b010:         f = (lo != 2'b00);
            default:        f = 1'b1;
        endcase
        return f | (st & f3[2]);
    endfunction

    // Lane extraction with sign or zero extension for loads.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [2:0] f3,
                                                 input logic [1:0] lo);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lo, 3'b000} +: 8];
        h = word[{lo[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b010:  r = word;
            3'b100:  r = {24'h000000, b};
            3'b101:  r = {16'h0000, h};
            default: r = 32'h00000000;
        endcase
        return r;
    endfunction

    // Read-modify-write merge of store data into the latched word.
    function automatic logic [31:0] store_merge(input logic [31:0] word,
                                                input logic [31:0] wd,
                                                input logic [2:0] f3,
                                                input logic [1:0] lo);
        logic [31:0] r;
        r = word;
        case (f3)
            3'b000:  r[{lo, 3'b000} +: 8] = wd[7:0];
            3'b001:  r[{lo[1], 4'b0000} +: 16] = wd[15:0];
            3'b010:  r = wd;
            default: r = word;
        endcase
        return r;
    endfunction

    // Request detection, access selection (live in IDLE, latched otherwise) and stall.
    always_comb begin
        req_s       = bus.mem_read | bus.mem_write;
        if (state_r == IDLE) begin
            sel_addr_s  = bus.addr[ADDR_W+1:0];
            sel_f3_s    = bus.funct3;
            sel_store_s = bus.mem_write;
        end else begin
            sel_addr_s  = addr_r;
            sel_f3_s    = f3_r;
            sel_store_s = store_r;
        end
        sel_fault_s = access_fault(sel_f3_s, sel_addr_s[1:0], sel_store_s);
        sel_word_s  = ram[sel_addr_s[ADDR_W+1:2]];
        bus.stall   = (state_r == WAIT) | ((state_r == IDLE) & req_s);
    end

    // Next-state and wait-counter logic.
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        enter_resp_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_s) begin
                    if (LAT == 4'd0) begin
                        state_nxt_s  = RESP;
                        enter_resp_s = 1'b1;
                    end else begin
                        state_nxt_s = WAIT;
                        cnt_nxt_s   = LAT;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r <= 4'd1) begin
                    state_nxt_s  = RESP;
                    cnt_nxt_s    = 4'd0;
                    enter_resp_s = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r - 4'd1;
                end
            end
            RESP:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Request latch and registered response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r  <= '0;
            wdata_r <= 32'h00000000;
            f3_r    <= 3'b000;
            store_r <= 1'b0;
            word_r  <= 32'h00000000;
            rdata_r <= 32'h00000000;
            done_r  <= 1'b0;
            fault_r <= 1'b0;
        end else begin
            if ((state_r == IDLE) && req_s) begin
                addr_r  <= bus.addr[ADDR_W+1:0];
                wdata_r <= bus.wdata;
                f3_r    <= bus.funct3;
                store_r <= bus.mem_write;
            end
            if (enter_resp_s) begin
                word_r  <= sel_word_s;
                done_r  <= 1'b1;
                fault_r <= sel_fault_s;
                rdata_r <= (sel_fault_s || sel_store_s) ? 32'h00000000
                           : load_extract(sel_word_s, sel_f3_s, sel_addr_s[1:0]);
            end else begin
                done_r  <= 1'b0;
                fault_r <= 1'b0;
                rdata_r <= 32'h00000000;
            end
        end
    end

    // RAM write on the edge that leaves RESP; a reset in RESP cancels it.
    always_ff @(posedge clk) begin
        if (!rst && (state_r == RESP) && store_r && !fault_r) begin
            ram[addr_r[ADDR_W+1:2]] <= store_merge(word_r, wdata_r, f3_r, addr_r[1:0]);
        end
    end

    assign bus.rdata = rdata_r;
    assign bus.done  = done_r;
    assign bus.fault = fault_r;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: byte-level memory model with per-cycle
// comparison of two builds (LATENCY=2 and LATENCY=0), plus literal checks.
module tb_data_mem_responder;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_mem_if bus0();
    data_mem_if bus2();

    data_mem_responder #(.DEPTH(DEPTH), .ADDR_W(10), .LATENCY(0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    data_mem_responder #(.DEPTH(DEPTH), .ADDR_W(10), .LATENCY(2)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2)
    );

    int checks = 0;
    int failures = 0;
    bit chk_on = 1'b0;
    logic        e_stall [2];
    logic        e_done  [2];
    logic        e_fault [2];
    logic [31:0] e_rdata [2];
    byte unsigned mm [int];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison of both DUTs against the model expectations.
    always @(negedge clk) begin
        if (chk_on) begin
            check("l0_stall", 32'(bus0.stall), 32'(e_stall[0]));
            check("l0_done",  32'(bus0.done),  32'(e_done[0]));
            check("l0_fault", 32'(bus0.fault), 32'(e_fault[0]));
            check("l0_rdata", bus0.rdata,      e_rdata[0]);
            check("l2_stall", 32'(bus2.stall), 32'(e_stall[1]));
            check("l2_done",  32'(bus2.done),  32'(e_done[1]));
            check("l2_fault", 32'(bus2.fault), 32'(e_fault[1]));
            check("l2_rdata", bus2.rdata,      e_rdata[1]);
        end
    end

    function automatic int m_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit m_fault(input bit st, input logic [2:0] f3, input logic [31:0] a);
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1'b1;
        if (st && f3 >= 3'b100) return 1'b1;
        return (int'(a[1:0]) % m_size(f3)) != 0;
    endfunction

    function automatic logic [31:0] m_load(input int w, input logic [2:0] f3, input logic [31:0] a);
        int sz;
        int ba;
        logic [31:0] v;
        sz = m_size(f3);
        ba = w * 65536 + int'(a % (4 * DEPTH));
        v = 32'h0;
        for (int i = 0; i < sz; i++) v = v | (32'(mm[ba + i]) << (8 * i));
        if (!f3[2] && sz < 4 && v[8 * sz - 1]) v = v | (32'hFFFFFFFF << (8 * sz));
        return v;
    endfunction

    task automatic m_store(input int w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        int ba;
        ba = w * 65536 + int'(a % (4 * DEPTH));
        for (int i = 0; i < m_size(f3); i++) mm[ba + i] = 8'(d >> (8 * i));
    endtask

    task automatic drive(input int w, input bit rd, input bit wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        if (w == 0) begin
            bus0.mem_read = rd; bus0.mem_write = wr; bus0.funct3 = f3;
            bus0.addr = a; bus0.wdata = d;
        end else begin
            bus2.mem_read = rd; bus2.mem_write = wr; bus2.funct3 = f3;
            bus2.addr = a; bus2.wdata = d;
        end
    endtask

    task automatic set_exp(input int w, input bit s, input bit dn, input bit f, input logic [31:0] r);
        e_stall[w] = s; e_done[w] = dn; e_fault[w] = f; e_rdata[w] = r;
    endtask

    // One complete access: request held while stalled, dropped in the done cycle.
    task automatic do_access(input int w, input bit rd, input bit wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] d,
                             output logic [31:0] got, output logic got_f);
        int lat;
        bit flt;
        logic [31:0] er;
        lat = (w == 1) ? 2 : 0;
        flt = m_fault(wr, f3, a);
        er = (flt || wr) ? 32'h0 : m_load(w, f3, a);
        for (int k = 0; k <= lat + 1; k++) begin
            @(posedge clk); #1;
            if (k <= lat) drive(w, rd, wr, f3, a, d);
            else drive(w, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
            set_exp(w, k <= lat, k == lat + 1, (k == lat + 1) && flt, (k == lat + 1) ? er : 32'h0);
        end
        @(negedge clk); #1;
        got   = (w == 1) ? bus2.rdata : bus0.rdata;
        got_f = (w == 1) ? bus2.fault : bus0.fault;
        set_exp(w, 1'b0, 1'b0, 1'b0, 32'h0);
        if (wr && !flt) m_store(w, f3, a, d);
    endtask

    logic [31:0] got;
    logic        gf;
    logic [31:0] er0;

    initial begin
        drive(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        set_exp(0, 1'b0, 1'b0, 1'b0, 32'h0);
        set_exp(1, 1'b0, 1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_on = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;

        // LATENCY=2: basic word store/load and sub-word extraction.
        do_access(1, 1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, got, gf);
        do_access(1, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, got, gf);
        check("lit_lw10", got, 32'hDEADBEEF);
        do_access(1, 1'b0, 1'b1, 3'b000, 32'h12, 32'h00000055, got, gf);
        do_access(1, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, got, gf);
        check("lit_lw10_sb", got, 32'hDE55BEEF);
        do_access(1, 1'b1, 1'b0, 3'b000, 32'h13, 32'h0, got, gf);
        check("lit_lb13", got, 32'hFFFFFFDE);
        do_access(1, 1'b1, 1'b0, 3'b100, 32'h13, 32'h0, got, gf);
        check("lit_lbu13", got, 32'h000000DE);
        do_access(1, 1'b1, 1'b0, 3'b001, 32'h12, 32'h0, got, gf);
        check("lit_lh12", got, 32'hFFFFDE55);
        do_access(1, 1'b1, 1'b0, 3'b101, 32'h12, 32'h0, got, gf);
        check("lit_lhu12", got, 32'h0000DE55);

        // Faults: misaligned load, misaligned store, reserved funct3.
        do_access(1, 1'b1, 1'b0, 3'b010, 32'h11, 32'h0, got, gf);
        check("lit_lw11_fault", 32'(gf), 32'h1);
        check("lit_lw11_rdata", got, 32'h0);
        do_access(1, 1'b0, 1'b1, 3'b001, 32'h13, 32'h00001234, got, gf);
        check("lit_sh13_fault", 32'(gf), 32'h1);
        do_access(1, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, got, gf);
        check("lit_lw10_after_sh", got, 32'hDE55BEEF);
        do_access(1, 1'b1, 1'b0, 3'b011, 32'h10, 32'h0, got, gf);
        check("lit_f3_011_fault", 32'(gf), 32'h1);

        // Reset during WAIT aborts the store.
        do_access(1, 1'b0, 1'b1, 3'b010, 32'h20, 32'h01020304, got, gf);
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b1, 3'b010, 32'h20, 32'hCAFEF00D);
        set_exp(1, 1'b1, 1'b0, 1'b0, 32'h0);
        @(posedge clk); #1;
        set_exp(1, 1'b1, 1'b0, 1'b0, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        set_exp(1, 1'b1, 1'b0, 1'b0, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        set_exp(1, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk); #1;
        check("lit_rst_stall", 32'(bus2.stall), 32'h0);
        check("lit_rst_done", 32'(bus2.done), 32'h0);
        do_access(1, 1'b1, 1'b0, 3'b010, 32'h20, 32'h0, got, gf);
        check("lit_lw20_after_rst", got, 32'h01020304);

        // Both requests high: store wins; address aliasing modulo 4*DEPTH.
        do_access(1, 1'b1, 1'b1, 3'b010, 32'h30, 32'h11111111, got, gf);
        do_access(1, 1'b1, 1'b0, 3'b010, 32'h30, 32'h0, got, gf);
        check("lit_lw30", got, 32'h11111111);
        do_access(1, 1'b1, 1'b0, 3'b010, 32'h30 + 4 * DEPTH, 32'h0, got, gf);
        check("lit_lw30_alias", got, 32'h11111111);
        do_access(1, 1'b0, 1'b1, 3'b010, 32'h30 + 4 * DEPTH, 32'h2468ACE0, got, gf);
        do_access(1, 1'b1, 1'b0, 3'b010, 32'h30, 32'h0, got, gf);
        check("lit_alias_store", got, 32'h2468ACE0);

        // LATENCY=0 build.
        do_access(0, 1'b0, 1'b1, 3'b010, 32'h40, 32'hA5A51234, got, gf);
        do_access(0, 1'b1, 1'b0, 3'b010, 32'h40, 32'h0, got, gf);
        check("lit_l0_lw40", got, 32'hA5A51234);
        do_access(0, 1'b1, 1'b0, 3'b001, 32'h42, 32'h0, got, gf);
        check("lit_l0_lh42", got, 32'hFFFFA5A5);

        // LATENCY=0: request held through RESP is re-accepted the next cycle.
        er0 = m_load(0, 3'b010, 32'h40);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            drive(0, 1'b1, 1'b0, 3'b010, 32'h40, 32'h0);
            set_exp(0, (k % 2) == 0, (k % 2) == 1, 1'b0, ((k % 2) == 1) ? er0 : 32'h0);
        end
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        set_exp(0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(posedge clk); #1;
        @(negedge clk); #1;
        chk_on = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
